mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the CPU's single memory port between the instruction-fetch channel and the load/store data channel. Grants one requester at a time, forwards its request handshake, then routes the matching read response back before re-arbitrating. Sits between the pipeline's IF/MEM stages and the memory/bus bridge. Allows exactly one outstanding transaction.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (strobe width DATA_W/8)

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- inst_req_valid  in  1  fetch request valid
- inst_req_ready  out  1  fetch request accepted
- inst_addr  in  ADDR_W  fetch address
- inst_rdata  out  DATA_W  fetched instruction
- inst_rdata_valid  out  1  fetch response valid
- inst_rdata_ready  in  1  fetch response accepted
- data_req_valid  in  1  load/store request valid
- data_req_ready  out  1  load/store request accepted
- data_addr  in  ADDR_W  load/store address
- data_wen  in  1  1 = store, 0 = load
- data_wdata  in  DATA_W  store data
- data_wstrb  in  DATA_W/8  store byte strobes
- data_rdata  out  DATA_W  load data
- data_rdata_valid  out  1  load response valid
- data_rdata_ready  in  1  load response accepted
- mem_req_valid  out  1  downstream request valid
- mem_req_ready  in  1  downstream request accepted
- mem_addr  out  ADDR_W  downstream address
- mem_wen  out  1  downstream write enable (0 for fetches)
- mem_wdata  out  DATA_W  downstream write data
- mem_wstrb  out  DATA_W/8  downstream strobes (0 for fetches)
- mem_rdata  in  DATA_W  downstream read data
- mem_rdata_valid  in  1  downstream response valid
- mem_rdata_ready  out  1  downstream response accepted

## Operation
- FSM states: IDLE, REQ_I, REQ_D, RESP_I, RESP_D.
- IDLE: no forwarding; all *_ready/*_valid outputs 0. If any request valid, register winner: → REQ_D or REQ_I. Neither valid: stay.
- Arbitration (default): data wins over inst on contention.
- REQ_x: mem_req_valid = x_req_valid; address/wen/wdata/wstrb muxed from x; x_req_ready = mem_req_ready; other requester's ready = 0. On mem_req_valid & mem_req_ready: load/fetch → RESP_x; store → IDLE (stores have no response).
- Requesters hold valid and payload stable until ready; a dropped valid in REQ_x leaves FSM in REQ_x with mem_req_valid = 0.
- RESP_x: x_rdata_valid = mem_rdata_valid; x_rdata = mem_rdata; mem_rdata_ready = x_rdata_ready. On handshake → IDLE.
- Outside RESP_x: mem_rdata_ready = 0, both rdata_valid = 0; mem_rdata_valid there is ignored (memory holds it).
- mem_wen/mem_wstrb forced 0 in REQ_I; all mem_* payload outputs 0 in IDLE/RESP states.
- inst_rdata/data_rdata are 0 when the corresponding rdata_valid is 0.

## Timing
- Reset: state IDLE; every output 0; last-grant register = inst.
- Reset mid-transaction abandons it: next cycle IDLE, outputs 0; downstream must be reset with the same rst.
- Arbitration latency: request seen in IDLE at cycle N → mem_req_valid earliest N+1.
- Request handshake in cycle M → response accepted earliest M+1; zero-wait memory gives a 3-cycle load/fetch (IDLE, REQ, RESP) and a 2-cycle store.
- Back-to-back: after RESP handshake the FSM spends one IDLE cycle before the next grant.
- All request-path and response-path outputs are combinational from the state register plus granted inputs; no input→output path for the ungranted requester.
- Simultaneous new request arriving during RESP_x waits; it is evaluated in the following IDLE cycle.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on contention in IDLE, grant the requester not recorded in last-grant; last-grant updates at every IDLE→REQ transition. Uncontended requests are granted immediately.
- Undefined: fixed priority, data over inst; last-grant register absent.

## Test plan
- Single fetch, zero-wait memory: inst_req_valid at cycle 1, addr 0x0000_1000, mem_rdata 0x0000_0013 → mem_req_valid cycle 2 with mem_wen 0, inst_rdata_valid cycle 3 with 0x0000_0013, FSM IDLE cycle 4.
- Store: data_wen 1, addr 0x100, wdata 0xDEADBEEF, wstrb 0xF → one downstream write beat with those values, no data_rdata_valid, back in IDLE next cycle.
- Contention, both valid continuously, 4 transactions: default build grants D,D,D,D (inst starved); ARB_ROUND_ROBIN_EN grants D,I,D,I.
- Backpressure: mem_req_ready low 3 cycles then high, inst_rdata_ready low 2 cycles during response → request/payload stable throughout, exactly one fetch completes, data_req_ready stays 0.
- Reset mid-RESP_D (rst high one cycle) → next cycle all outputs 0, state IDLE; new fetch then completes normally.
- Stray mem_rdata_valid asserted in IDLE → ignored, mem_rdata_ready 0, no rdata_valid to either requester.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory-port signal bundle around the arbiter
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                inst_req_valid;
   logic                inst_req_ready;
   logic [ADDR_W-1:0]   inst_addr;
   logic [DATA_W-1:0]   inst_rdata;
   logic                inst_rdata_valid;
   logic                inst_rdata_ready;
   logic                data_req_valid;
   logic                data_req_ready;
   logic [ADDR_W-1:0]   data_addr;
   logic                data_wen;
   logic [DATA_W-1:0]   data_wdata;
   logic [DATA_W/8-1:0] data_wstrb;
   logic [DATA_W-1:0]   data_rdata;
   logic                data_rdata_valid;
   logic                data_rdata_ready;
   logic                mem_req_valid;
   logic                mem_req_ready;
   logic [ADDR_W-1:0]   mem_addr;
   logic                mem_wen;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W/8-1:0] mem_wstrb;
   logic [DATA_W-1:0]   mem_rdata;
   logic                mem_rdata_valid;
   logic                mem_rdata_ready;
   modport master (
      input  inst_req_valid, inst_addr, inst_rdata_ready,
      input  data_req_valid, data_addr, data_wen, data_wdata, data_wstrb, data_rdata_ready,
      input  mem_req_ready, mem_rdata, mem_rdata_valid,
      output inst_req_ready, inst_rdata, inst_rdata_valid,
      output data_req_ready, data_rdata, data_rdata_valid,
      output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb, mem_rdata_ready
   );
   modport slave (
      output inst_req_valid, inst_addr, inst_rdata_ready,
      output data_req_valid, data_addr, data_wen, data_wdata, data_wstrb, data_rdata_ready,
      output mem_req_ready, mem_rdata, mem_rdata_valid,
      input  inst_req_ready, inst_rdata, inst_rdata_valid,
      input  data_req_ready, data_rdata, data_rdata_valid,
      input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb, mem_rdata_ready
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one-outstanding arbiter of fetch and load/store onto a single memory port (ARB_ROUND_ROBIN_EN selects round-robin contention)
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input logic clk,
   input logic rst,
   mem_port_arbiter_if.master bus
);
   typedef enum logic [2:0] {IDLE, REQ_I, REQ_D, RESP_I, RESP_D} state_t;
   state_t state, state_nxt;
   logic [ADDR_W-1:0] addr_sel;
   logic [DATA_W-1:0] wdata_sel;
   logic [DATA_W/8-1:0] wstrb_sel;
   logic grant_d;
`ifdef ARB_ROUND_ROBIN_EN
   logic last_d;
   // record which requester won the latest grant so contention alternates
   always_ff @(posedge clk)
      if (rst) last_d <= 1'b0;
      else if (state == IDLE && state_nxt != IDLE) last_d <= state_nxt == REQ_D;
   assign grant_d = bus.data_req_valid && !(bus.inst_req_valid && last_d);
`else
   assign grant_d = bus.data_req_valid;
`endif
   assign bus.mem_addr = addr_sel;
   assign bus.mem_wdata = wdata_sel;
   assign bus.mem_wstrb = wstrb_sel;
   // state register; reset abandons any transaction in flight
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else state <= state_nxt;
   // route the granted requester to the memory port and steer the response back
   always_comb begin
      state_nxt = state;
      bus.inst_req_ready = 1'b0;
      bus.inst_rdata = '0;
      bus.inst_rdata_valid = 1'b0;
      bus.data_req_ready = 1'b0;
      bus.data_rdata = '0;
      bus.data_rdata_valid = 1'b0;
      bus.mem_req_valid = 1'b0;
      bus.mem_wen = 1'b0;
      bus.mem_rdata_ready = 1'b0;
      addr_sel = '0;
      wdata_sel = '0;
      wstrb_sel = '0;
      case (state)
         IDLE: state_nxt = grant_d ? REQ_D : bus.inst_req_valid ? REQ_I : IDLE;
         REQ_I: begin
            bus.mem_req_valid = bus.inst_req_valid;
            addr_sel = bus.inst_addr;
            bus.inst_req_ready = bus.mem_req_ready;
            if (bus.inst_req_valid && bus.mem_req_ready) state_nxt = RESP_I;
         end
         REQ_D: begin
            bus.mem_req_valid = bus.data_req_valid;
            addr_sel = bus.data_addr;
            bus.mem_wen = bus.data_wen;
            wdata_sel = bus.data_wdata;
            wstrb_sel = bus.data_wstrb;
            bus.data_req_ready = bus.mem_req_ready;
            if (bus.data_req_valid && bus.mem_req_ready) state_nxt = bus.data_wen ? IDLE : RESP_D;
         end
         RESP_I: begin
            bus.inst_rdata_valid = bus.mem_rdata_valid;
            bus.inst_rdata = bus.mem_rdata_valid ? bus.mem_rdata : '0;
            bus.mem_rdata_ready = bus.inst_rdata_ready;
            if (bus.mem_rdata_valid && bus.inst_rdata_ready) state_nxt = IDLE;
         end
         RESP_D: begin
            bus.data_rdata_valid = bus.mem_rdata_valid;
            bus.data_rdata = bus.mem_rdata_valid ? bus.mem_rdata : '0;
            bus.mem_rdata_ready = bus.data_rdata_ready;
            if (bus.mem_rdata_valid && bus.data_rdata_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized transactions against a grant/route reference model
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int passed = 0;
   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
   logic [138:0] outs;
   assign outs = {bus.inst_req_ready, bus.inst_rdata, bus.inst_rdata_valid, bus.data_req_ready,
                  bus.data_rdata, bus.data_rdata_valid, bus.mem_req_valid, bus.mem_addr, bus.mem_wen,
                  bus.mem_wdata, bus.mem_wstrb, bus.mem_rdata_ready};
   always #5 clk = ~clk;

   task automatic clear_inputs();
      bus.inst_req_valid = 1'b0;
      bus.inst_addr = '0;
      bus.inst_rdata_ready = 1'b0;
      bus.data_req_valid = 1'b0;
      bus.data_addr = '0;
      bus.data_wen = 1'b0;
      bus.data_wdata = '0;
      bus.data_wstrb = '0;
      bus.data_rdata_ready = 1'b0;
      bus.mem_req_ready = 1'b0;
      bus.mem_rdata = '0;
      bus.mem_rdata_valid = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      bus.inst_req_valid = 1'b1;
      bus.data_req_valid = 1'b1;
      bus.mem_req_ready = 1'b1;
      bus.mem_rdata_valid = 1'b1;
      bus.mem_rdata = 32'hFFFF_FFFF;
      tick();
      @(negedge clk);
      checks++;
      if (outs !== '0) $display("FAIL reset_outputs got %h exp 0", outs); else passed++;
      do_reset();
   endtask

   task automatic test_fetch();
      do_reset();
      bus.inst_req_valid = 1'b1;
      bus.inst_addr = 32'h0000_1000;
      bus.mem_req_ready = 1'b1;
      bus.mem_rdata_valid = 1'b1;
      bus.mem_rdata = 32'h0000_0013;
      bus.inst_rdata_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (outs !== '0) $display("FAIL fetch_c1_idle got %h exp 0", outs); else passed++;
      tick();
      @(negedge clk);
      checks++;
      if ({bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wstrb, bus.inst_req_ready, bus.data_req_ready} !==
          {1'b1, 32'h0000_1000, 1'b0, 4'h0, 1'b1, 1'b0})
         $display("FAIL fetch_c2_req got v=%b a=%h w=%b s=%h ir=%b dr=%b exp v=1 a=00001000 w=0 s=0 ir=1 dr=0",
                  bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wstrb, bus.inst_req_ready, bus.data_req_ready);
      else passed++;
      tick();
      bus.inst_req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.inst_rdata_valid, bus.inst_rdata, bus.mem_rdata_ready, bus.mem_req_valid, bus.data_rdata_valid} !==
          {1'b1, 32'h0000_0013, 1'b1, 1'b0, 1'b0})
         $display("FAIL fetch_c3_resp got v=%b d=%h mr=%b exp v=1 d=00000013 mr=1",
                  bus.inst_rdata_valid, bus.inst_rdata, bus.mem_rdata_ready);
      else passed++;
      tick();
      @(negedge clk);
      checks++;
      if (outs !== '0) $display("FAIL fetch_c4_idle got %h exp 0", outs); else passed++;
      clear_inputs();
   endtask

   task automatic test_store();
      do_reset();
      bus.data_req_valid = 1'b1;
      bus.data_wen = 1'b1;
      bus.data_addr = 32'h0000_0100;
      bus.data_wdata = 32'hDEAD_BEEF;
      bus.data_wstrb = 4'hF;
      bus.data_rdata_ready = 1'b1;
      bus.mem_req_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (outs !== '0) $display("FAIL store_c1_idle got %h exp 0", outs); else passed++;
      tick();
      @(negedge clk);
      checks++;
      if ({bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wstrb, bus.data_req_ready, bus.inst_req_ready} !==
          {1'b1, 32'h0000_0100, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0})
         $display("FAIL store_beat got v=%b a=%h w=%b d=%h s=%h dr=%b exp v=1 a=00000100 w=1 d=deadbeef s=f dr=1",
                  bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wstrb, bus.data_req_ready);
      else passed++;
      tick();
      bus.data_req_valid = 1'b0;
      bus.mem_rdata_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (outs !== '0) $display("FAIL store_back_idle got %h exp 0", outs); else passed++;
      clear_inputs();
   endtask

   task automatic test_contention();
      logic [3:0] grants_d = '0;
      logic [3:0] exp_d;
      int n = 0;
`ifdef ARB_ROUND_ROBIN_EN
      exp_d = 4'b0101;
`else
      exp_d = 4'b1111;
`endif
      do_reset();
      bus.inst_req_valid = 1'b1;
      bus.inst_addr = 32'h0000_2000;
      bus.data_req_valid = 1'b1;
      bus.data_addr = 32'h0000_3000;
      bus.mem_req_ready = 1'b1;
      bus.mem_rdata_valid = 1'b1;
      bus.mem_rdata = 32'h1234_5678;
      bus.inst_rdata_ready = 1'b1;
      bus.data_rdata_ready = 1'b1;
      for (int c = 0; c < 24 && n < 4; c++) begin
         @(negedge clk);
         if (bus.data_req_ready || bus.inst_req_ready) begin
            grants_d[n] = bus.data_req_ready;
            n++;
         end
         tick();
      end
      checks++;
      if (n != 4) $display("FAIL contention_count got %0d exp 4", n); else passed++;
      checks++;
      if (grants_d !== exp_d) $display("FAIL contention_order got %b exp %b (bit i = data won txn i)", grants_d, exp_d); else passed++;
      do_reset();
   endtask

   task automatic test_backpressure();
      logic [31:0] a = $urandom;
      logic [31:0] r = $urandom;
      int done = 0;
      do_reset();
      bus.inst_req_valid = 1'b1;
      bus.inst_addr = a;
      tick();
      bus.data_req_valid = 1'b1;
      bus.data_addr = ~a;
      for (int k = 0; k < 4; k++) begin
         bus.mem_req_ready = (k == 3);
         @(negedge clk);
         checks++;
         if ({bus.mem_req_valid, bus.mem_addr, bus.inst_req_ready, bus.data_req_ready} !== {1'b1, a, k == 3, 1'b0})
            $display("FAIL bp_req_%0d got v=%b a=%h ir=%b dr=%b exp v=1 a=%h ir=%b dr=0", k,
                     bus.mem_req_valid, bus.mem_addr, bus.inst_req_ready, bus.data_req_ready, a, k == 3);
         else passed++;
         tick();
      end
      bus.inst_req_valid = 1'b0;
      bus.mem_req_ready = 1'b0;
      bus.mem_rdata_valid = 1'b1;
      bus.mem_rdata = r;
      for (int k = 0; k < 6; k++) begin
         bus.inst_rdata_ready = (k == 2);
         @(negedge clk);
         if (bus.inst_rdata_valid && bus.inst_rdata_ready) done++;
         if (k < 3) begin
            checks++;
            if ({bus.inst_rdata_valid, bus.inst_rdata, bus.mem_rdata_ready, bus.data_req_ready} !== {1'b1, r, k == 2, 1'b0})
               $display("FAIL bp_resp_%0d got v=%b d=%h mr=%b dr=%b exp v=1 d=%h mr=%b dr=0", k,
                        bus.inst_rdata_valid, bus.inst_rdata, bus.mem_rdata_ready, bus.data_req_ready, r, k == 2);
            else passed++;
         end
         tick();
      end
      checks++;
      if (done != 1) $display("FAIL bp_fetch_count got %0d exp 1", done); else passed++;
      do_reset();
   endtask

   task automatic test_reset_mid();
      logic [31:0] r = $urandom;
      int got = 0;
      do_reset();
      bus.data_req_valid = 1'b1;
      bus.data_addr = 32'h0000_0040;
      bus.mem_req_ready = 1'b1;
      bus.data_rdata_ready = 1'b1;
      tick();
      tick();
      bus.data_req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.mem_rdata_ready, bus.data_rdata_valid} !== 2'b10)
         $display("FAIL rstmid_in_resp got mr=%b dv=%b exp mr=1 dv=0", bus.mem_rdata_ready, bus.data_rdata_valid);
      else passed++;
      rst = 1'b1;
      bus.mem_rdata_valid = 1'b1;
      tick();
      rst = 1'b0;
      bus.mem_rdata_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (outs !== '0) $display("FAIL rstmid_outputs got %h exp 0", outs); else passed++;
      bus.inst_req_valid = 1'b1;
      bus.inst_addr = 32'h0000_0080;
      bus.inst_rdata_ready = 1'b1;
      bus.mem_rdata_valid = 1'b1;
      bus.mem_rdata = r;
      tick();
      for (int c = 0; c < 8 && got == 0; c++) begin
         @(negedge clk);
         if (bus.inst_rdata_valid) begin
            got = 1;
            checks++;
            if (bus.inst_rdata !== r) $display("FAIL rstmid_fetch_data got %h exp %h", bus.inst_rdata, r); else passed++;
         end
         if (bus.inst_req_ready) begin
            tick();
            bus.inst_req_valid = 1'b0;
         end else tick();
      end
      checks++;
      if (got != 1) $display("FAIL rstmid_fetch_done got %0d exp 1", got); else passed++;
      do_reset();
   endtask

   task automatic test_stray();
      do_reset();
      bus.mem_rdata_valid = 1'b1;
      bus.mem_rdata = $urandom | 32'h1;
      bus.inst_rdata_ready = 1'b1;
      bus.data_rdata_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (outs !== '0) $display("FAIL stray_rdata_%0d got %h exp 0", k, outs); else passed++;
         tick();
      end
      do_reset();
   endtask

   task automatic test_random();
      logic pi = 1'b0, pd = 1'b0, last_d = 1'b0, wd, acc, dw;
      logic [31:0] ia, da, dd, resp;
      logic [3:0] ds;
      logic [74:0] got_req, exp_req;
      logic [69:0] got_rsp, exp_rsp;
      int phase, cyc;
      do_reset();
      for (int t = 0; t < 40; t++) begin
         if (!pi && ($urandom_range(0, 1) == 1 || !pd)) begin
            pi = 1'b1;
            ia = $urandom;
            bus.inst_req_valid = 1'b1;
            bus.inst_addr = ia;
         end
         if (!pd && $urandom_range(0, 1) == 1) begin
            pd = 1'b1;
            da = $urandom;
            dw = 1'($urandom_range(0, 1));
            dd = $urandom;
            ds = 4'($urandom_range(1, 15));
            bus.data_req_valid = 1'b1;
            bus.data_addr = da;
            bus.data_wen = dw;
            bus.data_wdata = dd;
            bus.data_wstrb = ds;
         end
`ifdef ARB_ROUND_ROBIN_EN
         wd = (pi && pd) ? !last_d : pd;
`else
         wd = pd;
`endif
         last_d = wd;
         resp = $urandom;
         phase = 0;
         cyc = 0;
         while (phase < 3 && cyc < 80) begin
            acc = 1'b0;
            bus.mem_req_ready = 1'($urandom_range(0, 1));
            bus.mem_rdata_valid = 1'($urandom_range(0, 1));
            bus.mem_rdata = resp;
            bus.inst_rdata_ready = 1'($urandom_range(0, 1));
            bus.data_rdata_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (phase == 0) begin
               checks++;
               if (outs !== '0) $display("FAIL rand_idle txn %0d got %h exp 0", t, outs); else passed++;
               phase = 1;
            end else if (phase == 1) begin
               got_req = {bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wstrb,
                          bus.inst_req_ready, bus.data_req_ready, bus.inst_rdata_valid, bus.data_rdata_valid, bus.mem_rdata_ready};
               exp_req = wd ? {1'b1, da, dw, dd, ds, 1'b0, bus.mem_req_ready, 3'b000}
                            : {1'b1, ia, 1'b0, 32'h0, 4'h0, bus.mem_req_ready, 1'b0, 3'b000};
               checks++;
               if (got_req !== exp_req) $display("FAIL rand_req txn %0d got %h exp %h", t, got_req, exp_req); else passed++;
               if (bus.mem_req_ready) begin
                  acc = 1'b1;
                  phase = (wd && dw) ? 3 : 2;
               end
            end else begin
               got_rsp = {bus.inst_rdata_valid, bus.inst_rdata, bus.data_rdata_valid, bus.data_rdata,
                          bus.mem_rdata_ready, bus.mem_req_valid, bus.inst_req_ready, bus.data_req_ready};
               exp_rsp = wd ? {1'b0, 32'h0, bus.mem_rdata_valid, bus.mem_rdata_valid ? resp : 32'h0, bus.data_rdata_ready, 3'b000}
                            : {bus.mem_rdata_valid, bus.mem_rdata_valid ? resp : 32'h0, 1'b0, 32'h0, bus.inst_rdata_ready, 3'b000};
               checks++;
               if (got_rsp !== exp_rsp) $display("FAIL rand_resp txn %0d got %h exp %h", t, got_rsp, exp_rsp); else passed++;
               if (bus.mem_rdata_valid && (wd ? bus.data_rdata_ready : bus.inst_rdata_ready)) phase = 3;
            end
            tick();
            if (acc && wd) begin
               pd = 1'b0;
               bus.data_req_valid = 1'b0;
            end else if (acc) begin
               pi = 1'b0;
               bus.inst_req_valid = 1'b0;
            end
            cyc++;
         end
         if (phase != 3) begin
            checks++;
            $display("FAIL rand_timeout txn %0d phase %0d exp 3", t, phase);
         end
      end
      do_reset();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_fetch();
      test_store();
      test_contention();
      test_backpressure();
      test_reset_mid();
      test_stray();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
